// File: rtl/neuron_pu_stream.sv
// neuron_pu_stream: one neuron, LANES-wide sign-magnitude multiply-accumulate
// per beat, bias on the first beat, rescale/saturate to W-bit sign-magnitude.
// Optional macro PU_RELU_EN: clamp negative results to zero (ReLU).
module neuron_pu_stream #(
  parameter int W     = 8,
  parameter int LANES = 8,
  parameter int GUARD = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_first,
  input  logic               in_last,
  input  logic [LANES*W-1:0] x,
  input  logic [LANES*W-1:0] w,
  input  logic [W-1:0]       bias,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_data,
  output logic               err
);

  localparam int MAG_W  = W - 1;
  localparam int PROD_W = 2 * MAG_W;
  localparam int ACC_W  = PROD_W + 1 + $clog2(LANES) + GUARD;

  localparam logic signed [ACC_W:0]   SAT_POS = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0]   SAT_NEG = -SAT_POS;
  localparam logic signed [ACC_W-1:0] Q_POS   = {{(ACC_W-MAG_W){1'b0}}, {MAG_W{1'b1}}};
  localparam logic signed [ACC_W-1:0] Q_NEG   = -Q_POS;

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t               state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                 out_valid_q, out_valid_d;
  logic [W-1:0]         out_data_q, out_data_d;
  logic                 err_q, err_d;
  logic                 in_ready_q, in_ready_d;

  logic signed [ACC_W-1:0] prod [LANES];
  logic signed [ACC_W-1:0] beat_sum;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W:0]   sum_wide;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] q;
  logic signed [ACC_W-1:0] neg_q;
  logic [W-1:0]            res_sm;
  logic                    accept;

  assign accept    = in_valid && in_ready_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign err       = err_q;

  // Per-lane signed product; zero magnitude always yields +0.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [PROD_W-1:0] mag;
    logic              neg;
    logic [ACC_W-1:0]  ext;
    assign mag = {{MAG_W{1'b0}}, x[gi*W +: MAG_W]} * {{MAG_W{1'b0}}, w[gi*W +: MAG_W]};
    assign neg = x[gi*W + MAG_W] ^ w[gi*W + MAG_W];
    assign ext = {{(ACC_W-PROD_W){1'b0}}, mag};
    assign prod[gi] = (neg && (mag != '0)) ? -$signed(ext) : $signed(ext);
  end

  // Beat sum, bias alignment, saturating accumulate and output rescale.
  always_comb begin
    beat_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      beat_sum = beat_sum + prod[k];
    end
    bias_ext = {{(ACC_W-PROD_W){1'b0}}, bias[MAG_W-1:0], {MAG_W{1'b0}}};
    if (bias[W-1]) bias_ext = -bias_ext;
    base = ((state_q == IDLE) || in_first) ? bias_ext : acc_q;
    sum_wide = {base[ACC_W-1], base} + {beat_sum[ACC_W-1], beat_sum};
    if (sum_wide > SAT_POS)      acc_next = SAT_POS[ACC_W-1:0];
    else if (sum_wide < SAT_NEG) acc_next = SAT_NEG[ACC_W-1:0];
    else                         acc_next = sum_wide[ACC_W-1:0];
    // Arithmetic shift floors toward minus infinity, then clip to W-bit range.
    q     = acc_next >>> MAG_W;
    neg_q = -q;
    if (q > Q_POS)      res_sm = {1'b0, {MAG_W{1'b1}}};
    else if (q < Q_NEG) res_sm = {1'b1, {MAG_W{1'b1}}};
    else if (q < 0)     res_sm = {1'b1, neg_q[MAG_W-1:0]};
    else                res_sm = {1'b0, q[MAG_W-1:0]};
`ifdef PU_RELU_EN
    if (res_sm[W-1]) res_sm = '0;
`endif
  end

  // Next-state logic for the IDLE/ACC/HOLD handshake FSM.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    err_d       = 1'b0;
    case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          // A missing first in IDLE or a surprise first in ACC is a framing error.
          err_d = (state_q == IDLE) ? !in_first : in_first;
          if (in_last) begin
            state_d     = HOLD;
            acc_d       = '0;
            out_valid_d = 1'b1;
            out_data_d  = res_sm;
          end else begin
            state_d = ACC;
            acc_d   = acc_next;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d != HOLD);
  end

  // State and registered outputs; reset discards partial sums and held results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
    end
  end

endmodule

// File: doc/neuron_pu_stream.md
Name: neuron_pu_stream

Overview:
- Parametrised successor to the fixed 8-lane processing unit: one neuron, LANES-wide sign-magnitude multiply-accumulate per beat.
- Accumulates over any number of beats, adds a bias on the first beat, then rescales, saturates and (optionally) applies ReLU.
- Valid/ready handshake on input and output, with an output holding register.
- Sits between the layer controller (x/w streaming) and the layer output buffer.

Parameters:
- W, 8: data width of x, w, bias and out. Sign-magnitude: bit W-1 is the sign, bits W-2:0 are the fractional magnitude (Q1.(W-1)).
- LANES, 8: products summed per beat.
- GUARD, 6: extra accumulator headroom bits; ACC_W = 2*(W-1) + 1 + clog2(LANES) + GUARD.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  beat valid
- in_ready  output  1  beat accepted when in_valid && in_ready
- in_first  input  1  first beat of a neuron; bias is loaded
- in_last  input  1  final beat of a neuron
- x  input  LANES*W  lane k at bits [k*W+W-1 : k*W]
- w  input  LANES*W  same packing as x
- bias  input  W  sign-magnitude; sampled only on an accepted first beat
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out_data  output  W  sign-magnitude result
- err  output  1  one-cycle pulse on a framing error

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, acc=0.
  - out_valid=0, out_data=0, err=0, in_ready=0 while rst_n=0.
  - Reset mid-operation discards the partial sum and any held result.
- Products:
  - Per lane, magnitude = |x|*|w| (2*(W-1) bits); sign = x[W-1]^w[W-1].
  - Each product is converted to two's complement at ACC_W bits.
  - A zero magnitude gives +0.
- Bias: magnitude << (W-1), signed, extended to ACC_W.
- Beat sum S = sum of all LANES products; combinational, no pipeline stage.
- FSM states: IDLE, ACC, HOLD. in_ready=1 in IDLE and ACC, 0 in HOLD.
- Accepted beat:
  - acc_next = sat(base + S), with base = bias_ext if the beat is treated as first, else acc.
  - sat() clamps to ±(2^(ACC_W-1)-1) and never wraps.
- IDLE transitions:
  - Any accepted beat is treated as first.
  - If in_first=0, err pulses for 1 cycle.
  - Next state is HOLD if in_last, else ACC.
- ACC transitions:
  - Accepted beat with in_first=1: restart from bias_ext, partial sum discarded, err pulses.
  - in_last goes to HOLD; otherwise stay in ACC.
- in_first && in_last on the same beat: single-beat neuron, legal.
- Entering HOLD:
  - out_data is registered from acc_next the same edge, so out_valid=1 the cycle after the last beat is accepted (latency 1).
  - acc cleared to 0.
- HOLD:
  - out_valid and out_data remain stable until out_ready=1.
  - On that edge: out_valid←0, state←IDLE.
  - No bypass: in_ready stays 0 in the handshake cycle, so the next beat is accepted at the earliest 1 cycle later.
- Output conversion:
  - q = acc >>> (W-1), arithmetic shift, truncation toward −∞.
  - Clip q to [−(2^(W-1)−1), +(2^(W-1)−1)].
  - Convert to sign-magnitude; magnitude 0 always carries sign 0.
- in_valid=0 in any state leaves acc unchanged.

Optional Feature:
- PU_RELU_EN defined: after clipping, q<0 gives out_data=0, so out_data[W-1] is always 0.
- PU_RELU_EN undefined: the signed, clipped sign-magnitude result is output unchanged.
- The macro has no effect on handshake or latency.

Test Plan:
- Single-beat neuron (W=8, LANES=8):
  - first=last=1, lane0 x=0x40, w=0x40, other lanes 0, bias=0x00 → out_data=0x20, out_valid one cycle after acceptance.
  - Same stimulus with bias=0x10 → out_data=0x30.
- Three-beat neuron: lane0 0x40*0x40 each beat, first on beat 1, last on beat 3, bias 0 → out_data=0x60, err never pulses.
- Negative result: x=0xC0, w=0x40, bias 0, single beat → 0x00 with PU_RELU_EN, 0xA0 without.
- Saturation: all lanes x=w=0x7F, bias=0x7F, single beat → out_data=0x7F. Sign check: all lanes x=0xFF, w=0x7F → 0x00 with ReLU, 0xFF without.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - out_data stable throughout, in_ready=0.
  - out_ready=1 → out_valid falls next edge; in_ready=1 the following cycle.
- Framing and reset:
  - Beat in IDLE with in_first=0 → err pulses 1 cycle, bias still loaded.
  - in_first mid-ACC → err pulses, result excludes earlier beats.
  - rst_n=0 during ACC → out_valid=0, and the next neuron result is unaffected by the earlier partial sum.
